// File: rtl/crc_frame_sender.sv
// Transmit side of the CRC frame protocol. It sends the byte count, then the
// payload bytes, then the CRC-8 of the payload, and reports the checker's verdict.
`timescale 1ns/1ps
module crc_frame_sender #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'h07,
    parameter logic [WIDTH-1:0] INIT  = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_len,
    input  logic             pl_valid,
    output logic             pl_ready,
    input  logic [WIDTH-1:0] pl_data,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic [WIDTH-1:0] cnt_data,
    output logic             dat_valid,
    input  logic             dat_ready,
    output logic [WIDTH-1:0] dat_data,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic             res_data,
    output logic             done,
    output logic             pass,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_CNT,
        SEND_DATA,
        SEND_CRC,
        WAIT_RES
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] crc;
    logic             pl_fire;
    logic             dat_fire;

    // Serial MSB-first CRC update for one byte. Bits that shift out are dropped.
    function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] c,
                                                  input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        logic             fb;
        r = c;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            fb = r[WIDTH-1] ^ d[i];
            r  = (r << 1) ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    assign req_ready = (state == IDLE);
    assign res_ready = (state == WAIT_RES);
    assign busy      = (state != IDLE);
    // A new byte is taken only when the output register is empty or is emptied this cycle.
    assign pl_ready  = (state == SEND_DATA) && (remaining != '0) && (!dat_valid || dat_ready);
    assign pl_fire   = pl_valid && pl_ready;
    assign dat_fire  = dat_valid && dat_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            crc       <= INIT;
            cnt_valid <= 1'b0;
            cnt_data  <= '0;
            dat_valid <= 1'b0;
            dat_data  <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cnt_data  <= req_len;
                        remaining <= req_len;
                        crc       <= INIT;
                        cnt_valid <= 1'b1;
                        state     <= SEND_CNT;
                    end
                end
                SEND_CNT: begin
                    if (cnt_ready) begin
                        cnt_valid <= 1'b0;
                        if (remaining == '0) begin
                            dat_data  <= crc;
                            dat_valid <= 1'b1;
                            state     <= SEND_CRC;
                        end else begin
                            state <= SEND_DATA;
                        end
                    end
                end
                SEND_DATA: begin
                    if (pl_fire) begin
                        dat_data  <= pl_data;
                        dat_valid <= 1'b1;
                        crc       <= crc_step(crc, pl_data);
                        remaining <= remaining - WIDTH'(1);
                    end else if (dat_fire) begin
                        // The last payload byte is leaving, so the CRC follows with no bubble.
                        if (remaining == '0) begin
                            dat_data  <= crc;
                            dat_valid <= 1'b1;
                            state     <= SEND_CRC;
                        end else begin
                            dat_valid <= 1'b0;
                        end
                    end
                end
                SEND_CRC: begin
                    if (dat_ready) begin
                        dat_valid <= 1'b0;
                        state     <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        pass  <= res_data;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_sender.sv
// Self-checking bench for crc_frame_sender: random frames and stalls are checked
// against a byte-wise CRC-8 reference model.
`timescale 1ns/1ps
module tb_crc_frame_sender;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_ready;
    logic [7:0] req_len = 8'h00;
    logic       pl_valid = 1'b0, pl_ready;
    logic [7:0] pl_data = 8'h00;
    logic       cnt_valid, cnt_ready = 1'b0;
    logic [7:0] cnt_data;
    logic       dat_valid, dat_ready = 1'b0;
    logic [7:0] dat_data;
    logic       res_valid = 1'b0, res_ready, res_data = 1'b0;
    logic       done, pass, busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] pay [256];
    logic [7:0] got_data [$];
    int         got_cnt;
    bit         timed_out, done_seen, pass_seen, busy_after, done_next, pl_ready_any;
    int         unstable, overlap;

    crc_frame_sender dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .cnt_data(cnt_data),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .done(done), .pass(pass), .busy(busy)
    );

    always #5 clk = ~clk;

    // Byte-wise reference: fold the byte in, then do eight polynomial divisions.
    function automatic logic [7:0] ref_crc(input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = c ^ pay[i];
            for (int k = 0; k < 8; k++)
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Drives one whole frame and records what came out; checks live in the test tasks.
    task automatic run_frame(input int n, input bit stall, input bit verdict);
        int         cycles = 0, idx = 0, post = 0;
        bit         req_done = 0, pl_pend = 0, prev_stall = 0, finished = 0;
        logic [7:0] prev_data = 8'h00;
        got_data.delete();
        got_cnt = -1; timed_out = 0; done_seen = 0; pass_seen = 0; busy_after = 1;
        done_next = 1; pl_ready_any = 0; unstable = 0; overlap = 0;
        req_len  = n[7:0];
        res_data = verdict;
        while (!finished && cycles < 4000) begin
            @(posedge clk); #1;
            cycles++;
            if (post == 1) begin
                done_seen  = done;
                pass_seen  = pass;
                busy_after = busy;
                res_valid  = 1'b0;
                post       = 2;
                continue;
            end
            if (post == 2) begin
                done_next = done;
                finished  = 1;
                continue;
            end
            if (prev_stall && (dat_valid !== 1'b1 || dat_data !== prev_data)) unstable++;
            if (busy && req_ready) overlap++;
            req_valid = !req_done;
            cnt_ready = stall ? 1'($urandom % 2) : 1'b1;
            dat_ready = stall ? 1'($urandom % 2) : 1'b1;
            if (!pl_pend) pl_valid = (idx < n) && (stall ? ($urandom % 3 != 0) : 1'b1);
            pl_data   = (idx < n) ? pay[idx] : 8'h00;
            res_valid = (got_data.size() == n + 1) && (stall ? 1'($urandom % 2) : 1'b1);
            #1;
            if (pl_ready) pl_ready_any = 1;
            if (req_valid && req_ready) req_done = 1;
            if (cnt_valid && cnt_ready) got_cnt = int'(cnt_data);
            if (pl_valid && pl_ready) begin
                idx++;
                pl_pend = 0;
            end else begin
                pl_pend = pl_valid;
            end
            if (dat_valid && dat_ready) got_data.push_back(dat_data);
            prev_stall = dat_valid && !dat_ready;
            prev_data  = dat_data;
            if (res_valid && res_ready) post = 1;
        end
        timed_out = !finished;
        req_valid = 1'b0; pl_valid = 1'b0; cnt_ready = 1'b0; dat_ready = 1'b0; res_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({cnt_valid, dat_valid, done, pass, busy, req_ready, res_ready} !== 7'b0000010) begin
            errors++;
            $display("[TB] FAIL reset_flags got=%b want=0000010",
                     {cnt_valid, dat_valid, done, pass, busy, req_ready, res_ready});
        end
        checks++;
        if ({cnt_data, dat_data} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_data got=%h want=0000", {cnt_data, dat_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_byte;
        pay[0] = 8'h01;
        run_frame(1, 0, 1'b1);
        checks++;
        if (timed_out || got_cnt != 1 || got_data.size() != 2) begin
            errors++;
            $display("[TB] FAIL single_shape timeout=%0d cnt=%0d bytes=%0d want 0/1/2",
                     timed_out, got_cnt, got_data.size());
        end else begin
            checks++;
            if (got_data[0] !== 8'h01 || got_data[1] !== 8'h07) begin
                errors++;
                $display("[TB] FAIL single_bytes got=%h %h want=01 07", got_data[0], got_data[1]);
            end
        end
        checks++;
        if ({done_seen, pass_seen, busy_after, done_next} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL single_done got=%b want=1100 (done,pass,busy,done_next)",
                     {done_seen, pass_seen, busy_after, done_next});
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("[TB] FAIL req_while_busy got=%0d want=0", overlap);
        end
    endtask

    task automatic test_check_string;
        logic [71:0] s;
        s = "123456789";
        for (int i = 0; i < 9; i++) pay[i] = s[71 - 8*i -: 8];
        run_frame(9, 0, 1'b1);
        checks++;
        if (timed_out || got_cnt != 9 || got_data.size() != 10) begin
            errors++;
            $display("[TB] FAIL string_shape timeout=%0d cnt=%0d bytes=%0d want 0/9/10",
                     timed_out, got_cnt, got_data.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (got_data[i] !== pay[i]) begin
                    errors++;
                    $display("[TB] FAIL string_byte%0d got=%h want=%h", i, got_data[i], pay[i]);
                end
            end
            checks++;
            if (got_data[9] !== 8'hF4) begin
                errors++;
                $display("[TB] FAIL string_crc got=%h want=f4", got_data[9]);
            end
        end
    endtask

    task automatic test_zero_len;
        run_frame(0, 0, 1'b1);
        checks++;
        if (timed_out || got_cnt != 0 || got_data.size() != 1) begin
            errors++;
            $display("[TB] FAIL zero_shape timeout=%0d cnt=%0d bytes=%0d want 0/0/1",
                     timed_out, got_cnt, got_data.size());
        end else begin
            checks++;
            if (got_data[0] !== 8'h00) begin
                errors++;
                $display("[TB] FAIL zero_crc got=%h want=00", got_data[0]);
            end
        end
        checks++;
        if (pl_ready_any) begin
            errors++;
            $display("[TB] FAIL zero_pl_ready got=1 want=0");
        end
    endtask

    task automatic test_stalls;
        logic [7:0] clean_crc;
        for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
        run_frame(4, 0, 1'b1);
        clean_crc = (got_data.size() == 5) ? got_data[4] : 8'hxx;
        for (int rep = 0; rep < 3; rep++) begin
            run_frame(4, 1, 1'b1);
            checks++;
            if (timed_out || got_cnt != 4 || got_data.size() != 5) begin
                errors++;
                $display("[TB] FAIL stall_shape timeout=%0d cnt=%0d bytes=%0d want 0/4/5",
                         timed_out, got_cnt, got_data.size());
                continue;
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_data[i] !== pay[i]) begin
                    errors++;
                    $display("[TB] FAIL stall_byte%0d got=%h want=%h", i, got_data[i], pay[i]);
                end
            end
            checks++;
            if (got_data[4] !== ref_crc(4) || got_data[4] !== clean_crc) begin
                errors++;
                $display("[TB] FAIL stall_crc got=%h want=%h (unstalled %h)",
                         got_data[4], ref_crc(4), clean_crc);
            end
            checks++;
            if (unstable != 0) begin
                errors++;
                $display("[TB] FAIL stall_hold got=%0d changes want=0", unstable);
            end
        end
    endtask

    task automatic test_fail_verdict;
        pay[0] = 8'h01;
        run_frame(1, 0, 1'b0);
        checks++;
        if (timed_out || done_seen !== 1'b1 || pass_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL verdict0 got done=%b pass=%b want done=1 pass=0", done_seen, pass_seen);
        end
        run_frame(1, 0, 1'b1);
        checks++;
        if (timed_out || done_seen !== 1'b1 || pass_seen !== 1'b1) begin
            errors++;
            $display("[TB] FAIL verdict1 got done=%b pass=%b want done=1 pass=1", done_seen, pass_seen);
        end
    endtask

    task automatic test_res_ignored;
        res_data  = 1'b0;
        res_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({done, res_ready, pass} !== 3'b001) begin
                errors++;
                $display("[TB] FAIL idle_res got=%b want=001 (done,res_ready,pass)",
                         {done, res_ready, pass});
            end
        end
        res_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        int idx = 0, cycles = 0;
        bit req_done = 0;
        for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
        req_len = 8'd5; cnt_ready = 1'b1; dat_ready = 1'b1;
        while (idx < 2 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
            req_valid = !req_done;
            pl_valid  = 1'b1;
            pl_data   = pay[idx];
            #1;
            if (req_valid && req_ready) req_done = 1;
            if (pl_valid && pl_ready) idx++;
        end
        @(posedge clk); #1;
        pl_valid = 1'b0;
        checks++;
        if (idx != 2 || busy !== 1'b1 || dat_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midframe_setup got idx=%0d busy=%b dat_valid=%b want 2/1/1",
                     idx, busy, dat_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cnt_valid, dat_valid, done, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midframe_abort got=%b want=0000", {cnt_valid, dat_valid, done, busy});
        end
        req_valid = 1'b0; cnt_ready = 1'b0; dat_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pay[0] = 8'h01;
        run_frame(1, 0, 1'b1);
        checks++;
        if (timed_out || got_data.size() != 2 || got_data[got_data.size()-1] !== 8'h07) begin
            errors++;
            $display("[TB] FAIL midframe_reseed timeout=%0d bytes=%0d want crc=07",
                     timed_out, got_data.size());
        end
    endtask

    task automatic test_back_to_back;
        int  n;
        bit  v, st;
        for (int f = 0; f < 8; f++) begin
            n  = (f == 7) ? 255 : int'($urandom_range(0, 40));
            v  = 1'($urandom % 2);
            st = (f % 2 == 1);
            for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
            run_frame(n, st, v);
            checks++;
            if (timed_out || got_cnt != n || got_data.size() != n + 1) begin
                errors++;
                $display("[TB] FAIL frame%0d_shape timeout=%0d cnt=%0d bytes=%0d want 0/%0d/%0d",
                         f, timed_out, got_cnt, got_data.size(), n, n + 1);
                continue;
            end
            checks++;
            begin
                int bad = 0;
                for (int i = 0; i < n; i++) if (got_data[i] !== pay[i]) bad++;
                if (bad != 0) begin
                    errors++;
                    $display("[TB] FAIL frame%0d_payload got=%0d wrong bytes want=0", f, bad);
                end
            end
            checks++;
            if (got_data[n] !== ref_crc(n)) begin
                errors++;
                $display("[TB] FAIL frame%0d_crc got=%h want=%h", f, got_data[n], ref_crc(n));
            end
            checks++;
            if ({done_seen, pass_seen, done_next} !== {1'b1, v, 1'b0} || unstable != 0 || overlap != 0) begin
                errors++;
                $display("[TB] FAIL frame%0d_end got done=%b pass=%b next=%b unstable=%0d overlap=%0d want 1/%b/0/0/0",
                         f, done_seen, pass_seen, done_next, unstable, overlap, v);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_check_string;
        test_zero_len;
        test_stalls;
        test_fail_verdict;
        test_res_ignored;
        test_reset_mid_frame;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
